// File: rtl/ca_pkg.sv
// Shared definitions for the C/A code correlator.
//   DEF_ACC_W     : default signed accumulator width (holds +/-1023)
//   DEF_EPOCH_LEN : nominal chips per code epoch
//   CNT_W         : chip counter width (saturates at 2047)
//   state_e       : correlator FSM states
//   chip_agree()  : 1-bit chip correlation, +1 on agreement, -1 otherwise
package ca_pkg;

    localparam int DEF_ACC_W     = 11;
    localparam int DEF_EPOCH_LEN = 1023;
    localparam int CNT_W         = 11;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    function automatic logic signed [1:0] chip_agree(input logic sample, input logic ref_chip);
        return (sample == ref_chip) ? 2'sb01 : 2'sb11;
    endfunction

endpackage

// File: rtl/corr_acc.sv
// One signed epoch accumulator.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force the sum to zero (highest priority)
//   load     : restart the sum with contrib
//   add      : sum += contrib (wraps, no saturation)
//   contrib  : +1 / -1 chip contribution
//   acc      : current sum
module corr_acc #(
    parameter int ACC_W = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    load,
    input  logic                    add,
    input  logic signed [1:0]       contrib,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] contrib_ext;

    assign contrib_ext = ACC_W'(contrib);

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (load) begin
            acc_d = contrib_ext;
        end else if (add) begin
            acc_d = acc_q + contrib_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/ca_correlator.sv
// Single-channel 1-bit C/A correlator with early/prompt/late taps one chip apart.
// Accumulates over one code epoch and dumps the three sums through a valid/ready
// result register.
//   clk, rst            : clock, synchronous active-high reset
//   run                 : enable; low forces IDLE and clears the accumulators
//   chip_en             : one-cycle strobe per chip
//   code_chip           : local code chip (early phase)
//   epoch               : first chip of a code period, qualified by chip_en
//   sample_in           : sign bit of the received signal
//   e_sum/p_sum/l_sum   : dumped epoch sums
//   chip_count          : chips in the dumped epoch (saturating)
//   len_err             : dumped epoch length differs from EPOCH_LEN
//   out_valid/out_ready : result handshake
//   overrun             : sticky, a dump was lost because the result was unread
module ca_correlator
    import ca_pkg::*;
#(
    parameter int ACC_W     = DEF_ACC_W,
    parameter int EPOCH_LEN = DEF_EPOCH_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    chip_en,
    input  logic                    code_chip,
    input  logic                    epoch,
    input  logic                    sample_in,
    output logic signed [ACC_W-1:0] e_sum,
    output logic signed [ACC_W-1:0] p_sum,
    output logic signed [ACC_W-1:0] l_sum,
    output logic [CNT_W-1:0]        chip_count,
    output logic                    len_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    state_e           state_q, state_d;
    logic             d1_q, d2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_clr, acc_load, acc_add, dump;

    logic signed [1:0]       e_c, p_c, l_c;
    logic signed [ACC_W-1:0] e_acc, p_acc, l_acc;

    logic signed [ACC_W-1:0] e_sum_q, p_sum_q, l_sum_q;
    logic [CNT_W-1:0]        chip_count_q;
    logic                    len_err_q, valid_q, valid_d, overrun_q, overrun_d, load_res;

    // Code delay line shifts on every chip regardless of state, so the taps are
    // already aligned when the first epoch marker arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            d1_q <= 1'b0;
            d2_q <= 1'b0;
        end else if (chip_en) begin
            d1_q <= code_chip;
            d2_q <= d1_q;
        end
    end

    assign e_c = chip_agree(sample_in, code_chip);
    assign p_c = chip_agree(sample_in, d1_q);
    assign l_c = chip_agree(sample_in, d2_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_clr  = 1'b0;
        acc_load = 1'b0;
        acc_add  = 1'b0;
        dump     = 1'b0;
        if (!run) begin
            state_d = IDLE;
            acc_clr = 1'b1;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (chip_en && epoch) begin
                        state_d  = RUN;
                        acc_load = 1'b1;
                        cnt_d    = CNT_W'(1);
                    end else begin
                        acc_clr = 1'b1;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    if (chip_en && epoch) begin
                        // Dump excludes this chip; it seeds the next epoch.
                        dump     = 1'b1;
                        acc_load = 1'b1;
                        cnt_d    = CNT_W'(1);
                    end else if (chip_en) begin
                        acc_add = 1'b1;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    corr_acc #(.ACC_W(ACC_W)) u_acc_e (
        .clk(clk), .rst(rst), .clr(acc_clr), .load(acc_load), .add(acc_add),
        .contrib(e_c), .acc(e_acc)
    );

    corr_acc #(.ACC_W(ACC_W)) u_acc_p (
        .clk(clk), .rst(rst), .clr(acc_clr), .load(acc_load), .add(acc_add),
        .contrib(p_c), .acc(p_acc)
    );

    corr_acc #(.ACC_W(ACC_W)) u_acc_l (
        .clk(clk), .rst(rst), .clr(acc_clr), .load(acc_load), .add(acc_add),
        .contrib(l_c), .acc(l_acc)
    );

    // A dump while the old result is unread and not being accepted is dropped.
    always_comb begin
        valid_d   = valid_q;
        overrun_d = overrun_q;
        load_res  = 1'b0;
        if (dump) begin
            if (!valid_q || out_ready) begin
                load_res = 1'b1;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_sum_q      <= '0;
            p_sum_q      <= '0;
            l_sum_q      <= '0;
            chip_count_q <= '0;
            len_err_q    <= 1'b0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (load_res) begin
                e_sum_q      <= e_acc;
                p_sum_q      <= p_acc;
                l_sum_q      <= l_acc;
                chip_count_q <= cnt_q;
                len_err_q    <= (cnt_q != CNT_W'(EPOCH_LEN));
            end
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign e_sum      = e_sum_q;
    assign p_sum      = p_sum_q;
    assign l_sum      = l_sum_q;
    assign chip_count = chip_count_q;
    assign len_err    = len_err_q;
    assign out_valid  = valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ca_correlator.sv
// Scoreboard bench for ca_correlator: the stimulus process pushes the expected
// dump for each epoch, a negedge monitor pops and compares on every accepted result.
module tb_ca_correlator;

    localparam int ACC_W = 11;

    logic                    clk;
    logic                    rst;
    logic                    run;
    logic                    chip_en;
    logic                    code_chip;
    logic                    epoch;
    logic                    sample_in;
    logic signed [ACC_W-1:0] e_sum, p_sum, l_sum;
    logic [10:0]             chip_count;
    logic                    len_err;
    logic                    out_valid;
    logic                    out_ready;
    logic                    overrun;

    ca_correlator #(.ACC_W(ACC_W), .EPOCH_LEN(1023)) dut (
        .clk(clk), .rst(rst), .run(run), .chip_en(chip_en), .code_chip(code_chip),
        .epoch(epoch), .sample_in(sample_in), .e_sum(e_sum), .p_sum(p_sum),
        .l_sum(l_sum), .chip_count(chip_count), .len_err(len_err),
        .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
    );

    typedef struct {
        int e, p, l, cnt;
        bit len_err;
        bit ce, cp, cl, bound;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   unexp = 0;
    bit   code[1023];
    logic prev_chip = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // PRN 1 Gold code: G1 output xor G2 taps 2 and 6.
    task automatic gen_code();
        logic [10:1] g1, g2;
        logic        fb1, fb2;
        g1 = '1;
        g2 = '1;
        for (int i = 0; i < 1023; i++) begin
            code[i] = g1[10] ^ g2[2] ^ g2[6];
            fb1 = g1[3] ^ g1[10];
            fb2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
            g1 = {g1[9:1], fb1};
            g2 = {g2[9:1], fb2};
        end
    endtask

    // mode: 0 sample=code, 1 sample=code delayed one chip, 2 inverted, 3 zero.
    // Gaps after some chips (others back-to-back) carry stray epoch pulses.
    task automatic run_epoch(input int mode, input int len, input bit mark);
        logic c, s;
        for (int i = 0; i < len; i++) begin
            c = code[i];
            case (mode)
                0:       s = c;
                1:       s = prev_chip;
                2:       s = ~c;
                default: s = 1'b0;
            endcase
            code_chip = c;
            sample_in = s;
            epoch     = mark && (i == 0);
            chip_en   = 1'b1;
            tick();
            prev_chip = c;
            chip_en   = 1'b0;
            epoch     = 1'b0;
            if (i % 3 != 0) begin
                epoch = (i % 7 == 3);
                tick();
                epoch = 1'b0;
            end
        end
    endtask

    function automatic exp_t mk(input int e, input int p, input int l, input int cnt,
                                input bit le, input bit ce, input bit cp, input bit cl,
                                input bit bound);
        exp_t x;
        x.e = e; x.p = p; x.l = l; x.cnt = cnt; x.len_err = le;
        x.ce = ce; x.cp = cp; x.cl = cl; x.bound = bound;
        return x;
    endfunction

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_e_sum"}, e_sum, 0);
        chk({tag, "_p_sum"}, p_sum, 0);
        chk({tag, "_l_sum"}, l_sum, 0);
        chk({tag, "_chip_count"}, chip_count, 0);
        chk({tag, "_len_err"}, len_err, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    // Monitor: a result is consumed on the next posedge when valid & ready.
    always @(negedge clk) begin
        exp_t x;
        int   pv, lv;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                if (unexp < 10)
                    $display("FAIL unexpected_result: got out_valid=1 e_sum=%0d expected none",
                             e_sum);
                unexp++;
            end else begin
                x = q.pop_front();
                pv = p_sum;
                lv = l_sum;
                if (x.ce) chk("res_e_sum", e_sum, x.e);
                if (x.cp) chk("res_p_sum", p_sum, x.p);
                if (x.cl) chk("res_l_sum", l_sum, x.l);
                chk("res_chip_count", chip_count, x.cnt);
                chk("res_len_err", len_err, x.len_err);
                if (x.bound) begin
                    chk("res_p_bound", (pv <= x.cnt && pv >= -x.cnt) ? 1 : 0, 1);
                    chk("res_l_bound", (lv <= x.cnt && lv >= -x.cnt) ? 1 : 0, 1);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        run       = 1'b1;
        chip_en   = 1'b0;
        code_chip = 1'b0;
        epoch     = 1'b0;
        sample_in = 1'b0;
        out_ready = 1'b1;
        gen_code();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_zero_outputs("reset");

        run_epoch(0, 1023, 1);                               // E0 sample = code
        q.push_back(mk(1023, 0, 0, 1023, 0, 1, 0, 0, 0));
        run_epoch(1, 1023, 1);                               // E1 sample = prompt code
        q.push_back(mk(0, 1023, 0, 1023, 0, 0, 1, 0, 0));
        run_epoch(2, 1023, 1);                               // E2 inverted
        q.push_back(mk(-1023, 0, 0, 1023, 0, 1, 0, 0, 0));
        run_epoch(3, 1023, 1);                               // E3 held 0: 512 ones
        q.push_back(mk(-1, -1, -1, 1023, 0, 1, 1, 1, 0));
        run_epoch(0, 500, 1);                                // E4 short epoch
        q.push_back(mk(500, 0, 0, 500, 1, 1, 0, 0, 1));
        run_epoch(0, 1023, 1);                               // E5

        out_ready = 1'b0;
        q.push_back(mk(1023, 0, 0, 1023, 0, 1, 0, 0, 0));
        run_epoch(2, 1023, 1);                               // E6, dump of E5 held
        run_epoch(3, 1023, 1);                               // E7, dump of E6 lost
        chk("ovr_overrun", overrun, 1);
        chk("ovr_out_valid", out_valid, 1);
        chk("ovr_e_sum_kept", e_sum, 1023);
        chk("ovr_count_kept", chip_count, 1023);
        q.push_back(mk(-1, -1, -1, 1023, 0, 1, 1, 1, 0));
        out_ready = 1'b1;                                    // accept on the dump cycle
        run_epoch(0, 300, 1);                                // E8 partial

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_zero_outputs("midrst");
        chk("midrst_queue_empty", q.size(), 0);

        run_epoch(0, 1023, 1);                               // E9 first epoch after reset
        out_ready = 1'b0;
        q.push_back(mk(1023, 0, 0, 1023, 0, 1, 0, 0, 0));
        run_epoch(0, 200, 1);                                // E10 dumps E9, pending
        run = 1'b0;
        run_epoch(0, 300, 0);
        run = 1'b1;
        run_epoch(0, 100, 0);
        chk("runlow_out_valid", out_valid, 1);
        chk("runlow_e_sum", e_sum, 1023);
        chk("runlow_chip_count", chip_count, 1023);
        chk("runlow_len_err", len_err, 0);
        out_ready = 1'b1;
        tick();
        tick();
        run_epoch(2, 1023, 1);                               // E11 enters RUN, no dump
        q.push_back(mk(-1023, 0, 0, 1023, 0, 1, 0, 0, 0));
        run_epoch(0, 5, 1);                                  // E12 dumps E11
        repeat (5) tick();
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
